// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path (and a future transmit path).
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered head output.
// A push and a pop in the same cycle are both honoured, including when full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] head_next;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_next = do_pop ? rd_ptr + AW'(1) : rd_ptr;

  always_comb begin
    cnt_next = cnt;
    case ({do_push, do_pop})
      2'b10:   cnt_next = cnt + CW'(1);
      2'b01:   cnt_next = cnt - CW'(1);
      default: cnt_next = cnt;
    endcase
  end

  // The pushed word becomes the head only when nothing older survives this cycle;
  // otherwise the next head is an entry that is not being overwritten now.
  always_comb begin
    head_next = head;
    if (do_push && (empty || (cnt == CW'(1) && do_pop))) begin
      head_next = wdata;
    end else if (cnt_next != '0) begin
      head_next = mem[rd_next];
    end
  end

  // NOTE: the storage array has no reset; count/pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      head   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_next;
      cnt    <= cnt_next;
      head   <= head_next;
    end
  end

  assign rdata = head;
  assign count = cnt;

endmodule

// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver: synchronizes the line, samples mid-bit, decodes LSB-first
// and buffers bytes in a FIFO exposed as a valid/ready stream.
module uart_rx_capture
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk50mhz,
  input  logic                          sys_rst_n,
  input  logic                          rxd_i,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

  logic                 sync1;
  logic                 rxs;
  logic                 rxs_d;
  logic                 fall;
  rx_state_t            state;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 tick;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 stop_tick;
  logic                 push;
  logic                 full;
  logic                 empty;

  // Two-flop synchronizer plus one edge register; idle line is high.
  always_ff @(posedge clk50mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rxd_i;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  assign fall      = rxs_d & ~rxs;
  assign tick      = (bit_cnt == '0);
  assign stop_tick = (state == STOP) && tick;
  assign push      = stop_tick & rxs;

  always_ff @(posedge clk50mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fall) begin
            state   <= START;
            bit_cnt <= HALF_LOAD;
          end
        end
        START: begin
          if (!tick) begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end else if (rxs) begin
            state <= IDLE;
          end else begin
            state   <= DATA;
            bit_idx <= '0;
            bit_cnt <= FULL_LOAD;
          end
        end
        DATA: begin
          if (!tick) begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end else begin
            shreg   <= {rxs, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + IDX_W'(1);
            bit_cnt <= FULL_LOAD;
            if (bit_idx == LAST_IDX) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          // Returning to IDLE right at the mid-stop sample lets the next start edge resync.
          if (!tick) begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pulses are mutually exclusive by construction: one needs the stop bit high, the other low.
  always_ff @(posedge clk50mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_tick & ~rxs;
      overrun   <= push & full & ~rx_ready;
    end
  end

  assign busy     = (state != IDLE);
  assign rx_valid = ~empty;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk50mhz),
    .rst_n (sys_rst_n),
    .push  (push),
    .wdata (shreg),
    .pop   (rx_ready),
    .rdata (rx_data),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_capture.sv
// Directed bench for uart_rx_capture: drives 8N1 frames, scoreboards received bytes
// and watches the error pulses and busy timing from a negedge monitor.
module tb_uart_rx_capture;

  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD   = 1_000_000;
  localparam int BIT    = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int DEPTH  = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic [4:0] fifo_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb_q[$];

  int   pop_cnt  = 0;
  int   fe_cnt   = 0;
  int   ov_cnt   = 0;
  int   rise_cnt = 0;
  int   fall_cnt = 0;
  logic busy_q = 1'b0, valid_q = 1'b0, fe_q = 1'b0, ov_q = 1'b0;
  logic fall_valid = 1'b0, fall_prev_valid = 1'b0, fall_fe = 1'b0;
  logic [4:0] fall_count = '0;

  always #10 clk = ~clk;

  uart_rx_capture #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk50mhz   (clk),
    .sys_rst_n  (rst_n),
    .rxd_i      (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // An empty scoreboard yields a value no 8-bit output can match.
  function automatic logic [31:0] sb_next();
    if (sb_q.size() != 0) return {24'h0, sb_q.pop_front()};
    return 32'h100;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) begin
        check("rx_data", {24'h0, rx_data}, sb_next());
        pop_cnt <= pop_cnt + 1;
      end
      if (frame_err || overrun) check("pulse_excl", {31'h0, frame_err & overrun}, 32'h0);
      if (frame_err) begin
        check("fe_width", {31'h0, fe_q}, 32'h0);
        fe_cnt <= fe_cnt + 1;
      end
      if (overrun) begin
        check("ov_width", {31'h0, ov_q}, 32'h0);
        ov_cnt <= ov_cnt + 1;
      end
      if (busy_q && !busy) begin
        fall_cnt        <= fall_cnt + 1;
        fall_valid      <= rx_valid;
        fall_prev_valid <= valid_q;
        fall_fe         <= frame_err;
        fall_count      <= fifo_count;
      end
      if (!busy_q && busy) rise_cnt <= rise_cnt + 1;
      busy_q  <= busy;
      valid_q <= rx_valid;
      fe_q    <= frame_err;
      ov_q    <= overrun;
    end else begin
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end
  end

  task automatic wait_bits(input int n);
    repeat (n * BIT) @(posedge clk);
    #2;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Drives one frame; with lat=1 also checks the line-edge to busy latency of 3 cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit lat);
    rxd = 1'b0;
    if (lat) begin
      repeat (3) @(negedge clk);
      check("busy_lat2", {31'h0, busy}, 32'h0);
      @(negedge clk);
      check("busy_lat3", {31'h0, busy}, 32'h1);
      repeat (BIT - 3) @(posedge clk);
      #2;
    end else begin
      wait_bits(1);
    end
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_bits(1);
    end
    rxd = stop;
    wait_bits(1);
    rxd = 1'b1;
  endtask

  initial begin
    int fe0, ov0, pop0, rise0, fall0;
    logic [7:0] part;

    rst_n    = 1'b0;
    rxd      = 1'b1;
    rx_ready = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    check("rst_valid", {31'h0, rx_valid}, 32'h0);
    check("rst_busy",  {31'h0, busy},     32'h0);
    check("rst_count", {27'h0, fifo_count}, 32'h0);
    check("rst_data",  {24'h0, rx_data},  32'h0);
    check("rst_fe",    {31'h0, frame_err}, 32'h0);
    check("rst_ov",    {31'h0, overrun},  32'h0);
    rst_n = 1'b1;
    wait_bits(1);

    // 1. single good frame, held until accepted
    rx_ready = 1'b0;
    sb_q.push_back(8'h55);
    pop0 = pop_cnt;
    send_frame(8'h55, 1'b1, 1'b1);
    check("t1_prev_valid", {31'h0, fall_prev_valid}, 32'h0);
    check("t1_fall_valid", {31'h0, fall_valid}, 32'h1);
    check("t1_fall_count", {27'h0, fall_count}, 32'h1);
    check("t1_data", {24'h0, rx_data}, 32'h55);
    check("t1_count", {27'h0, fifo_count}, 32'h1);
    rx_ready = 1'b1;
    wait_cycles(4);
    check("t1_drained", {27'h0, fifo_count}, 32'h0);
    check("t1_pops", pop_cnt - pop0, 32'd1);
    check("t1_no_fe", fe_cnt, 32'd0);
    check("t1_no_ov", ov_cnt, 32'd0);
    wait_bits(1);

    // 2. stop bit low
    fe0 = fe_cnt;
    send_frame(8'hA3, 1'b0, 1'b0);
    wait_bits(1);
    check("t2_fe_cnt", fe_cnt - fe0, 32'd1);
    check("t2_fe_at_fall", {31'h0, fall_fe}, 32'h1);
    check("t2_valid", {31'h0, rx_valid}, 32'h0);
    check("t2_count", {27'h0, fifo_count}, 32'h0);

    // 3. 100 ns glitch on an idle line
    rise0 = rise_cnt;
    fall0 = fall_cnt;
    fe0   = fe_cnt;
    rxd = 1'b0;
    wait_cycles(5);
    rxd = 1'b1;
    wait_bits(1);
    check("t3_busy_rise", rise_cnt - rise0, 32'd1);
    check("t3_busy_fall", fall_cnt - fall0, 32'd1);
    check("t3_busy", {31'h0, busy}, 32'h0);
    check("t3_no_fe", fe_cnt - fe0, 32'd0);
    check("t3_valid", {31'h0, rx_valid}, 32'h0);

    // 4. fill past capacity with the consumer stalled, then drain
    rx_ready = 1'b0;
    ov0  = ov_cnt;
    pop0 = pop_cnt;
    for (int i = 0; i < 17; i++) begin
      if (i < DEPTH) sb_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, 1'b0);
      wait_cycles(3);
      if (i == DEPTH - 1) begin
        check("t4_full_count", {27'h0, fifo_count}, 32'd16);
        check("t4_no_ov_yet", ov_cnt - ov0, 32'd0);
      end
    end
    check("t4_count", {27'h0, fifo_count}, 32'd16);
    check("t4_ov", ov_cnt - ov0, 32'd1);
    check("t4_head", {24'h0, rx_data}, 32'h00);
    rx_ready = 1'b1;
    wait_cycles(20);
    check("t4_pops", pop_cnt - pop0, 32'd16);
    check("t4_valid", {31'h0, rx_valid}, 32'h0);
    check("t4_sb_empty", sb_q.size(), 32'd0);

    // 5. back-to-back frames with no idle gap
    fe0  = fe_cnt;
    pop0 = pop_cnt;
    sb_q.push_back(8'h01);
    sb_q.push_back(8'hFF);
    sb_q.push_back(8'h80);
    send_frame(8'h01, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h80, 1'b1, 1'b0);
    wait_bits(2);
    check("t5_pops", pop_cnt - pop0, 32'd3);
    check("t5_no_fe", fe_cnt - fe0, 32'd0);
    check("t5_sb_empty", sb_q.size(), 32'd0);

    // 6. reset mid-frame while bytes are buffered
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    wait_cycles(3);
    check("t6_hold", {27'h0, fifo_count}, 32'd2);
    part = 8'h3C;
    rxd = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 4; i++) begin
      rxd = part[i];
      wait_bits(1);
    end
    rxd = part[4];
    wait_cycles(BIT / 2);
    check("t6_busy_pre", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_count", {27'h0, fifo_count}, 32'h0);
    check("t6_rst_busy", {31'h0, busy}, 32'h0);
    check("t6_rst_valid", {31'h0, rx_valid}, 32'h0);
    wait_cycles(5);
    rst_n    = 1'b1;
    rxd      = 1'b1;
    rx_ready = 1'b1;
    wait_bits(2);
    pop0 = pop_cnt;
    sb_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b0);
    wait_bits(1);
    check("t6_pops", pop_cnt - pop0, 32'd1);
    check("t6_sb_empty", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
